dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Arbitrates the single-port data memory between the pipeline MEM stage (CPU) and the debug/display reader (board Addr switches / 7-seg path).
- CPU has priority. A starvation counter forces a debug slot after STARVE_LIMIT consecutive CPU-won cycles, and the CPU is stalled for that one cycle.
- Sits between the MEM stage and the data RAM. cpu_stall feeds the pipeline hazard/stall network.

Parameters:
- ADDR_W, 6, word address width of the data memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, max CPU-won cycles while debug is waiting. 0 = debug wins its first waiting cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage access valid this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  mem_rdata pass-through; valid the cycle after a CPU read grant.
- cpu_stall  out  1  combinational; high when cpu_req=1 and debug holds the port this cycle.
- dbg_req  in  1  level request from the debug reader.
- dbg_addr  in  ADDR_W  debug read address; sampled when the request is accepted.
- dbg_rdata  out  DATA_W  registered debug read data.
- dbg_ack  out  1  one-cycle pulse; dbg_rdata valid.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous-read memory output; 1-cycle latency.

Behaviour:
- Reset (asynchronous): state=IDLE, wait_cnt=0, dbg_addr_q=0, dbg_rdata=0, dbg_ack=0. Any pending debug read is dropped.
- wait_cnt width: clog2(STARVE_LIMIT+1), minimum 1 bit. Saturates; never wraps.
- States:
  - IDLE: dbg_req=1 at the edge → latch dbg_addr into dbg_addr_q, wait_cnt=0, go to WAIT.
  - WAIT: dbg_gnt = !cpu_req | (wait_cnt==STARVE_LIMIT).
    - dbg_gnt=1 → go to RD, wait_cnt=0.
    - dbg_gnt=0 (CPU wins) → wait_cnt+1.
  - RD: capture mem_rdata into dbg_rdata, go to ACK. The port is free to the CPU in this state.
  - ACK: dbg_ack=1, go to IDLE. dbg_req is ignored in ACK.
- Requester protocol: dbg_req held until ack. If dbg_req is still high in the cycle after ACK, it is treated as a new request.
- Port mux (combinational):
  - dbg_gnt=1: mem_en=1, mem_we=0, mem_addr=dbg_addr_q, mem_wdata=0.
  - Otherwise: mem_en=cpu_req, mem_we=cpu_req&cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
- cpu_stall = cpu_req & dbg_gnt. It is high for exactly one cycle per debug read, and only when the CPU was requesting.
- Minimum debug latency: req sampled at edge 0 → grant in cycle 1 → capture in cycle 2 → dbg_ack in cycle 3.
- Worst-case debug latency: STARVE_LIMIT+3 cycles.
- Stall contract: while cpu_stall=1, the pipeline freezes PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB. The CPU retries the same access next cycle.
- Ordering: accesses are never simultaneous. A CPU write granted before the debug grant is visible to the debug read.

Test Plan:
- Reset, then CPU writes 0xDEADBEEF to addr 5 and reads addr 5, no debug traffic → mem_we pulse once; cpu_rdata=0xDEADBEEF one cycle after the read grant; cpu_stall stays 0.
- mem[3]=0x12345678, cpu_req=0, dbg_req=1 addr 3 at edge 0 → grant (mem_addr=3) in cycle 1; dbg_ack and dbg_rdata=0x12345678 in cycle 3; cpu_stall never 1.
- cpu_req held 1 continuously, STARVE_LIMIT=8, dbg_req at edge 0 → CPU wins cycles 1-8; debug granted in cycle 9 with cpu_stall=1 for exactly that cycle; dbg_ack in cycle 11.
- CPU writes 0xA5A5A5A5 to addr 7 in the cycle before debug is granted for addr 7 → dbg_rdata=0xA5A5A5A5.
- reset asserted asynchronously while in RD → dbg_ack never pulses; dbg_rdata=0; state IDLE; cpu_stall=0 immediately.
- dbg_req held high through ACK and one more cycle → a second debug read is issued, with a second dbg_ack 4 cycles after the first.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: CPU MEM-stage side, debug reader side, RAM side.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
    output cpu_rdata, cpu_stall, dbg_rdata, dbg_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_rdata, dbg_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the CPU MEM stage (priority) and the debug reader,
// with a starvation counter that forces one debug slot (stalling the CPU) after STARVE_LIMIT losses.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD,
    ACK
  } state_t;

  state_t            state;
  logic [CW-1:0]     waitCnt;
  logic [ADDR_W-1:0] dbgAddrQ;
  logic [DATA_W-1:0] dbgRdataQ;
  logic              dbgAckQ;
  logic              dbgGnt;

  always_comb begin
    dbgGnt = (state == WAIT) && (!bus.cpu_req || (waitCnt == LIMIT));
  end

  always_comb begin
    if (dbgGnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = dbgAddrQ;
      bus.mem_wdata = '0;
    end else begin
      bus.mem_en    = bus.cpu_req;
      bus.mem_we    = bus.cpu_req & bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & dbgGnt;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dbg_rdata = dbgRdataQ;
  assign bus.dbg_ack   = dbgAckQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= '0;
      dbgAddrQ  <= '0;
      dbgRdataQ <= '0;
      dbgAckQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dbg_req) begin
            dbgAddrQ <= bus.dbg_addr;
            waitCnt  <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (dbgGnt) begin
            waitCnt <= '0;
            state   <= RD;
          end else if (waitCnt != LIMIT) begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        // RAM data for the grant cycle arrives now; ack is raised alongside it.
        RD: begin
          dbgRdataQ <= bus.mem_rdata;
          dbgAckQ   <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          dbgAckQ <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          dbgAckQ <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a synchronous-read RAM model and
// scoreboard queues for CPU and debug read data.
module tb_dmem_port_arbiter;
  localparam int ADDR_W       = 6;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem [64];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] dbgQ [$];
  logic [DATA_W-1:0] cpuQ [$];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, '0, '0);
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = '0;
    repeat (2) @(posedge clk);
    sample();
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.dbg_rdata); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", bus.mem_en); end
    bus.cpu_req = 1'b1;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall); end
    next_cycle();
    reset = 1'b0;
    bus.cpu_req = 1'b0;
  endtask

  task automatic test_cpu_rw();
    int weCount = 0;
    next_cycle();
    cpu_drive(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
    sample();
    weCount += int'(bus.mem_we);
    checks++; if (bus.mem_addr !== 6'd5 || bus.mem_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL cpu_wr_bus: got addr %0d data %h want 5 deadbeef", bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %b want 0", bus.cpu_stall); end
    next_cycle();
    cpu_drive(1'b1, 1'b0, 6'd5, 32'h0);
    sample();
    weCount += int'(bus.mem_we);
    if (bus.mem_en === 1'b1) cpuQ.push_back(32'hDEADBEEF);
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall: got %b want 0", bus.cpu_stall); end
    next_cycle();
    cpu_drive(1'b0, 1'b0, '0, '0);
    sample();
    weCount += int'(bus.mem_we);
    checks++;
    if (cpuQ.size() == 0) begin errors++; $display("FAIL cpu_rd_grant: got no read grant want one"); end
    else begin
      logic [DATA_W-1:0] exp = cpuQ.pop_front();
      if (bus.cpu_rdata !== exp) begin errors++; $display("FAIL cpu_rdata: got %h want %h", bus.cpu_rdata, exp); end
    end
    checks++; if (weCount != 1) begin errors++; $display("FAIL cpu_we_pulses: got %0d want 1", weCount); end
  endtask

  task automatic test_dbg_basic();
    int ackCyc = -1, gntCyc = -1, stallSeen = 0;
    next_cycle();
    cpu_drive(1'b1, 1'b1, 6'd3, 32'h12345678);
    sample();
    next_cycle();
    cpu_drive(1'b0, 1'b0, '0, '0);
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 6'd3;
    dbgQ.push_back(32'h12345678);
    sample();
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL dbg_c0_idle: got mem_en %b want 0", bus.mem_en); end
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (ackCyc >= 0) bus.dbg_req = 1'b0;
      sample();
      if (bus.cpu_stall === 1'b1) stallSeen++;
      if (gntCyc < 0 && bus.mem_en === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr === 6'd3) gntCyc = c;
      if (bus.dbg_ack === 1'b1) begin
        if (ackCyc < 0) ackCyc = c;
        checks++;
        if (dbgQ.size() == 0) begin errors++; $display("FAIL dbg_extra_ack: got ack in cycle %0d want none", c); end
        else begin
          logic [DATA_W-1:0] exp = dbgQ.pop_front();
          if (bus.dbg_rdata !== exp) begin errors++; $display("FAIL dbg_rdata: got %h want %h", bus.dbg_rdata, exp); end
        end
      end
    end
    checks++; if (gntCyc != 1) begin errors++; $display("FAIL dbg_gnt_cycle: got %0d want 1", gntCyc); end
    checks++; if (ackCyc != 3) begin errors++; $display("FAIL dbg_ack_cycle: got %0d want 3", ackCyc); end
    checks++; if (stallSeen != 0) begin errors++; $display("FAIL dbg_stall: got %0d want 0", stallSeen); end
    checks++; if (dbgQ.size() != 0) begin errors++; $display("FAIL dbg_missing_ack: got %0d pending want 0", dbgQ.size()); dbgQ.delete(); end
  endtask

  task automatic test_starve();
    int ackCyc = -1, stallCyc = -1, stallCnt = 0;
    next_cycle();
    cpu_drive(1'b1, 1'b0, 6'd10, '0);
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 6'd3;
    dbgQ.push_back(32'h12345678);
    sample();
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (ackCyc >= 0) bus.dbg_req = 1'b0;
      sample();
      if (bus.cpu_stall === 1'b1) begin
        stallCnt++;
        stallCyc = c;
        checks++; if (bus.mem_addr !== 6'd3 || bus.mem_we !== 1'b0) begin
          errors++; $display("FAIL starve_gnt_bus: got addr %0d we %b want 3 0", bus.mem_addr, bus.mem_we); end
      end
      if (bus.dbg_ack === 1'b1) begin
        if (ackCyc < 0) ackCyc = c;
        checks++;
        if (dbgQ.size() == 0) begin errors++; $display("FAIL starve_extra_ack: got ack in cycle %0d want none", c); end
        else begin
          logic [DATA_W-1:0] exp = dbgQ.pop_front();
          if (bus.dbg_rdata !== exp) begin errors++; $display("FAIL starve_rdata: got %h want %h", bus.dbg_rdata, exp); end
        end
      end
    end
    checks++; if (stallCnt != 1) begin errors++; $display("FAIL starve_stall_count: got %0d want 1", stallCnt); end
    checks++; if (stallCyc != STARVE_LIMIT + 1) begin errors++; $display("FAIL starve_stall_cycle: got %0d want %0d", stallCyc, STARVE_LIMIT + 1); end
    checks++; if (ackCyc != STARVE_LIMIT + 3) begin errors++; $display("FAIL starve_ack_cycle: got %0d want %0d", ackCyc, STARVE_LIMIT + 3); end
    checks++; if (dbgQ.size() != 0) begin errors++; $display("FAIL starve_missing_ack: got %0d pending want 0", dbgQ.size()); dbgQ.delete(); end
    next_cycle();
    cpu_drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_order();
    int ackCyc = -1;
    next_cycle();
    cpu_drive(1'b1, 1'b1, 6'd7, 32'h11111111);
    sample();
    next_cycle();
    cpu_drive(1'b0, 1'b0, '0, '0);
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 6'd7;
    dbgQ.push_back(32'hA5A5A5A5);
    sample();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 1) cpu_drive(1'b1, 1'b1, 6'd7, 32'hA5A5A5A5);
      else cpu_drive(1'b0, 1'b0, '0, '0);
      if (ackCyc >= 0) bus.dbg_req = 1'b0;
      sample();
      if (c == 1) begin
        checks++; if (bus.mem_we !== 1'b1 || bus.cpu_stall !== 1'b0) begin
          errors++; $display("FAIL order_cpu_wins: got we %b stall %b want 1 0", bus.mem_we, bus.cpu_stall); end
      end
      if (bus.dbg_ack === 1'b1) begin
        if (ackCyc < 0) ackCyc = c;
        checks++;
        if (dbgQ.size() == 0) begin errors++; $display("FAIL order_extra_ack: got ack in cycle %0d want none", c); end
        else begin
          logic [DATA_W-1:0] exp = dbgQ.pop_front();
          if (bus.dbg_rdata !== exp) begin errors++; $display("FAIL order_rdata: got %h want %h", bus.dbg_rdata, exp); end
        end
      end
    end
    checks++; if (ackCyc != 4) begin errors++; $display("FAIL order_ack_cycle: got %0d want 4", ackCyc); end
    checks++; if (dbgQ.size() != 0) begin errors++; $display("FAIL order_missing_ack: got %0d pending want 0", dbgQ.size()); dbgQ.delete(); end
  endtask

  task automatic test_reset_rd();
    int ackCnt = 0;
    next_cycle();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 6'd5;
    sample();
    next_cycle();
    sample();
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 6'd5) begin
      errors++; $display("FAIL rstrd_gnt: got en %b addr %0d want 1 5", bus.mem_en, bus.mem_addr); end
    @(posedge clk);
    #2;
    cpu_drive(1'b1, 1'b0, 6'd9, '0);
    reset = 1'b1;
    #1;
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL rstrd_ack: got %b want 0", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL rstrd_rdata: got %h want 0", bus.dbg_rdata); end
    checks++; if (bus.cpu_stall !== 1'b0 || bus.mem_addr !== 6'd9) begin
      errors++; $display("FAIL rstrd_port: got stall %b addr %0d want 0 9", bus.cpu_stall, bus.mem_addr); end
    bus.dbg_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      sample();
      if (bus.dbg_ack === 1'b1) ackCnt++;
    end
    checks++; if (ackCnt != 0) begin errors++; $display("FAIL rstrd_no_ack: got %0d acks want 0", ackCnt); end
    checks++; if (bus.dbg_rdata !== 32'h0 || bus.cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rstrd_idle: got rdata %h stall %b want 0 0", bus.dbg_rdata, bus.cpu_stall); end
    cpu_drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    int ack1 = -1, ack2 = -1;
    next_cycle();
    bus.dbg_req  = 1'b1;
    bus.dbg_addr = 6'd5;
    dbgQ.push_back(32'hDEADBEEF);
    sample();
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      bus.dbg_req = (ack1 < 0) || (c <= ack1 + 1);
      if (ack1 >= 0 && c == ack1 + 1) begin
        bus.dbg_addr = 6'd3;
        dbgQ.push_back(32'h12345678);
      end
      sample();
      if (bus.dbg_ack === 1'b1) begin
        if (ack1 < 0) ack1 = c;
        else if (ack2 < 0) ack2 = c;
        checks++;
        if (dbgQ.size() == 0) begin errors++; $display("FAIL b2b_extra_ack: got ack in cycle %0d want none", c); end
        else begin
          logic [DATA_W-1:0] exp = dbgQ.pop_front();
          if (bus.dbg_rdata !== exp) begin errors++; $display("FAIL b2b_rdata: got %h want %h", bus.dbg_rdata, exp); end
        end
      end
    end
    checks++; if (ack1 != 3) begin errors++; $display("FAIL b2b_ack1_cycle: got %0d want 3", ack1); end
    checks++; if (ack2 != 7) begin errors++; $display("FAIL b2b_ack2_cycle: got %0d want 7", ack2); end
    checks++; if (dbgQ.size() != 0) begin errors++; $display("FAIL b2b_missing_ack: got %0d pending want 0", dbgQ.size()); dbgQ.delete(); end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_dbg_basic();
    test_starve();
    test_order();
    test_reset_rd();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
